// File: rtl/gate_vec_serializer_pkg.sv
// gate_vec_serializer shared types and Q6.11 fixed-point constants.
// Imported by the serializer top and the saturating adder.
package gate_vec_serializer_pkg;

   localparam int QN       = 6;
   localparam int QM       = 11;
   localparam int BITWIDTH = QN + QM + 1;

   localparam logic signed [BITWIDTH-1:0] SAT_MAX =
      {1'b0, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [BITWIDTH-1:0] SAT_MIN =
      {1'b1, {(BITWIDTH-1){1'b0}}};

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/gate_vec_serializer_fxp_add_sat.sv
// fxp_add_sat: two's complement add with clip to the BITWIDTH range.
// Combinational; sat reports that the true sum was out of range.
import gate_vec_serializer_pkg::*;

module fxp_add_sat #(
   parameter int BITWIDTH = gate_vec_serializer_pkg::BITWIDTH
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   output logic [BITWIDTH-1:0] sum,
   output logic                sat
);

   localparam logic [BITWIDTH-1:0] MAXV =
      {1'b0, {(BITWIDTH-1){1'b1}}};
   localparam logic [BITWIDTH-1:0] MINV =
      {1'b1, {(BITWIDTH-1){1'b0}}};

   logic [BITWIDTH:0] wide;

   // one guard bit; top two bits disagree exactly on overflow
   always_comb begin
      wide = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
      sat  = wide[BITWIDTH] ^ wide[BITWIDTH-1];
      sum  = wide[BITWIDTH-1:0];
      if (sat) sum = wide[BITWIDTH] ? MINV : MAXV;
   end

endmodule

// File: rtl/gate_vec_serializer.sv
// gate_vec_serializer: drains a dot-product vector row by row as sat(dot+bias).
// GATE_SAT_FLAG_EN adds outSat and the satCount saturation counter.
module gate_vec_serializer
   import gate_vec_serializer_pkg::*;
#(
   parameter int NROW              = 16,
   parameter int ROW_ADDR_BITWIDTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         dataReady,
   input  logic [NROW*BITWIDTH-1:0]     dotVec,
   input  logic [NROW*BITWIDTH-1:0]     biasVec,
   output logic [BITWIDTH-1:0]          outData,
   output logic [ROW_ADDR_BITWIDTH-1:0] outRowIdx,
   output logic                         outValid,
   input  logic                         outReady,
   output logic                         vecDone,
   output logic                         busy,
`ifdef GATE_SAT_FLAG_EN
   output logic                         outSat,
   output logic [15:0]                  satCount,
`endif
   output logic                         overrun
);

   state_t state, state_nxt;

   logic capture;
   logic advance;
   logic done_nxt;
   logic ovr_set;
   logic xfer;
   logic last;

   logic [BITWIDTH-1:0] dot_buf  [NROW];
   logic [BITWIDTH-1:0] bias_buf [NROW];

   logic [ROW_ADDR_BITWIDTH-1:0] row_nxt;
   logic [BITWIDTH-1:0]          add_a;
   logic [BITWIDTH-1:0]          add_b;
   logic [BITWIDTH-1:0]          sum;
   logic                         sum_sat;

   assign outValid = (state == STREAM);
   assign busy     = (state == STREAM);
   assign xfer     = outValid & outReady;
   assign last     = (outRowIdx == ROW_ADDR_BITWIDTH'(NROW-1));
   assign row_nxt  = outRowIdx + 1'b1;

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state: capture on idle or on last-row handoff, else advance
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      advance   = 1'b0;
      done_nxt  = 1'b0;
      ovr_set   = 1'b0;
      unique case (1'b1)
         (state == IDLE): begin
            if (dataReady) begin
               capture   = 1'b1;
               state_nxt = STREAM;
            end
         end
         (state == STREAM): begin
            if (xfer && last) begin
               done_nxt = 1'b1;
               if (dataReady) capture   = 1'b1;
               else           state_nxt = IDLE;
            end else begin
               if (xfer)      advance = 1'b1;
               if (dataReady) ovr_set = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // operand mux: fresh row 0 from the inputs, else the next buffered row
   always_comb begin
      add_a = dot_buf[row_nxt];
      add_b = bias_buf[row_nxt];
      if (capture) begin
         add_a = dotVec[BITWIDTH-1:0];
         add_b = biasVec[BITWIDTH-1:0];
      end
   end

   fxp_add_sat #(
      .BITWIDTH(BITWIDTH)
   ) u_add (
      .a  (add_a),
      .b  (add_b),
      .sum(sum),
      .sat(sum_sat)
   );

   // vector buffers, loaded only on an accepted dataReady
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NROW; i++) begin
            dot_buf[i]  <= '0;
            bias_buf[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NROW; i++) begin
            dot_buf[i]  <= dotVec[i*BITWIDTH +: BITWIDTH];
            bias_buf[i] <= biasVec[i*BITWIDTH +: BITWIDTH];
         end
      end
   end

   // output register; held whenever nothing is loaded (stall)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outData   <= '0;
         outRowIdx <= '0;
      end else if (capture) begin
         outData   <= sum;
         outRowIdx <= '0;
      end else if (advance) begin
         outData   <= sum;
         outRowIdx <= row_nxt;
      end
   end

   // end-of-vector pulse and sticky overrun
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vecDone <= 1'b0;
         overrun <= 1'b0;
      end else begin
         vecDone <= done_nxt;
         if (ovr_set) overrun <= 1'b1;
      end
   end

`ifdef GATE_SAT_FLAG_EN
   // clip flag tracks outData; counter counts clipped transfers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outSat   <= 1'b0;
         satCount <= '0;
      end else begin
         if (capture || advance) outSat <= sum_sat;
         if (xfer && outSat && satCount != 16'hFFFF)
            satCount <= satCount + 16'd1;
      end
   end
`else
   logic sat_unused;
   assign sat_unused = sum_sat;
`endif

   a_stall_stable: assert property (
      @(posedge clock) disable iff (!reset)
      (outValid && !outReady) |=> ($stable(outData) && $stable(outRowIdx) && outValid)
   );

   a_row_range: assert property (
      @(posedge clock) disable iff (!reset)
      outRowIdx <= ROW_ADDR_BITWIDTH'(NROW-1)
   );

endmodule

// File: tb/tb_gate_vec_serializer.sv
// Directed bench for gate_vec_serializer.
// Inputs change and outputs are checked on the falling clock edge.
module tb_gate_vec_serializer;

   localparam int NROW = 16;
   localparam int BW   = 18;

   logic clock     = 1'b0;
   logic reset     = 1'b0;
   logic dataReady = 1'b0;
   logic outReady  = 1'b0;

   logic [NROW*BW-1:0] dotVec;
   logic [NROW*BW-1:0] biasVec;
   logic [BW-1:0]      dv [NROW];
   logic [BW-1:0]      bv [NROW];

   logic [BW-1:0] outData;
   logic [3:0]    outRowIdx;
   logic          outValid;
   logic          vecDone;
   logic          busy;
   logic          overrun;
`ifdef GATE_SAT_FLAG_EN
   logic          outSat;
   logic [15:0]   satCount;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   always_comb begin
      dotVec  = '0;
      biasVec = '0;
      for (int i = 0; i < NROW; i++) begin
         dotVec[i*BW +: BW]  = dv[i];
         biasVec[i*BW +: BW] = bv[i];
      end
   end

   gate_vec_serializer dut (
      .clock    (clock),
      .reset    (reset),
      .dataReady(dataReady),
      .dotVec   (dotVec),
      .biasVec  (biasVec),
      .outData  (outData),
      .outRowIdx(outRowIdx),
      .outValid (outValid),
      .outReady (outReady),
      .vecDone  (vecDone),
      .busy     (busy),
`ifdef GATE_SAT_FLAG_EN
      .outSat   (outSat),
      .satCount (satCount),
`endif
      .overrun  (overrun)
   );

   task automatic test_reset();
      reset     = 1'b0;
      dataReady = 1'b1;
      outReady  = 1'b1;
      for (int i = 0; i < NROW; i++) begin
         dv[i] = BW'($urandom);
         bv[i] = BW'($urandom);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (outValid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b want 0", outValid);
      end
      checks++;
      if (outData !== '0) begin
         errors++; $display("FAIL reset_data got %0h want 0", outData);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (overrun !== 1'b0 || vecDone !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got ovr=%b done=%b want 0 0", overrun, vecDone);
      end
      dataReady = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got v=%b b=%b want 0 0", outValid, busy);
      end
   endtask

   task automatic test_basic();
      logic [BW-1:0] exp;
      for (int i = 0; i < NROW; i++) begin
         dv[i] = BW'(512);
         bv[i] = BW'(i);
      end
      outReady  = 1'b1;
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      for (int i = 0; i < NROW; i++) begin
         exp = BW'(512 + i);
         checks++;
         if (outValid !== 1'b1 || outRowIdx !== 4'(i)) begin
            errors++;
            $display("FAIL basic_row%0d got v=%b row=%0d want 1 %0d", i, outValid, outRowIdx, i);
         end
         checks++;
         if (outData !== exp || vecDone !== 1'b0) begin
            errors++;
            $display("FAIL basic_data%0d got %0d done=%b want %0d 0", i, $signed(outData), vecDone, $signed(exp));
         end
`ifdef GATE_SAT_FLAG_EN
         checks++;
         if (outSat !== 1'b0) begin
            errors++; $display("FAIL basic_sat%0d got %b want 0", i, outSat);
         end
`endif
         @(negedge clock);
      end
      checks++;
      if (vecDone !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end got done=%b v=%b b=%b want 1 0 0", vecDone, outValid, busy);
      end
      @(negedge clock);
      checks++;
      if (vecDone !== 1'b0) begin
         errors++; $display("FAIL basic_done_pulse got %b want 0", vecDone);
      end
   endtask

   task automatic test_saturation();
      logic [BW-1:0] exp;
      for (int i = 0; i < NROW; i++) begin
         dv[i] = '0;
         bv[i] = '0;
      end
      dv[0] = BW'(131071);  bv[0] = BW'(1);
      dv[1] = BW'(-131072); bv[1] = BW'(-1);
      dv[2] = BW'(-5);      bv[2] = BW'(3);
      outReady  = 1'b1;
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      for (int i = 0; i < NROW; i++) begin
         case (i)
            0:       exp = BW'(131071);
            1:       exp = BW'(-131072);
            2:       exp = BW'(-2);
            default: exp = '0;
         endcase
         checks++;
         if (outData !== exp || outRowIdx !== 4'(i)) begin
            errors++;
            $display("FAIL sat_data%0d got %0d row=%0d want %0d", i, $signed(outData), outRowIdx, $signed(exp));
         end
`ifdef GATE_SAT_FLAG_EN
         checks++;
         if (outSat !== (i < 2)) begin
            errors++; $display("FAIL sat_flag%0d got %b want %b", i, outSat, i < 2);
         end
`endif
         @(negedge clock);
      end
      checks++;
      if (vecDone !== 1'b1 || outValid !== 1'b0) begin
         errors++; $display("FAIL sat_end got done=%b v=%b want 1 0", vecDone, outValid);
      end
`ifdef GATE_SAT_FLAG_EN
      checks++;
      if (satCount !== 16'd2) begin
         errors++; $display("FAIL sat_count got %0d want 2", satCount);
      end
`endif
      @(negedge clock);
   endtask

   task automatic test_backpressure();
      logic          pat [6];
      logic [BW-1:0] exp;
      int            r;
      int            k;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < NROW; i++) begin
         dv[i] = BW'(-100 * i);
         bv[i] = BW'(7);
      end
      outReady  = 1'b0;
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      r = 0;
      k = 0;
      while (r < NROW && k < 200) begin
         exp = BW'(-100 * r + 7);
         checks++;
         if (outValid !== 1'b1 || outRowIdx !== 4'(r) || outData !== exp) begin
            errors++;
            $display("FAIL bp_cycle%0d got v=%b row=%0d d=%0d want 1 %0d %0d", k, outValid, outRowIdx, $signed(outData), r, $signed(exp));
         end
         outReady = pat[k % 6];
         if (pat[k % 6]) r++;
         k++;
         @(negedge clock);
      end
      checks++;
      if (k >= 200) begin
         errors++; $display("FAIL bp_budget got %0d transfers want 16", r);
      end
      checks++;
      if (vecDone !== 1'b1 || outValid !== 1'b0) begin
         errors++; $display("FAIL bp_end got done=%b v=%b want 1 0", vecDone, outValid);
      end
      outReady = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] exp;
      int            dones;
      for (int i = 0; i < NROW; i++) begin
         dv[i] = BW'(10 * i);
         bv[i] = '0;
      end
      outReady  = 1'b1;
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      for (int i = 0; i < NROW; i++) begin
         exp = BW'(10 * i);
         checks++;
         if (outValid !== 1'b1 || outRowIdx !== 4'(i) || outData !== exp) begin
            errors++;
            $display("FAIL b2b_a%0d got v=%b row=%0d d=%0d want 1 %0d %0d", i, outValid, outRowIdx, $signed(outData), i, $signed(exp));
         end
         if (i == NROW-1) begin
            for (int j = 0; j < NROW; j++) begin
               dv[j] = BW'(2000 + j);
               bv[j] = BW'(-j);
            end
            dataReady = 1'b1;
         end
         @(negedge clock);
      end
      dataReady = 1'b0;
      dones = 0;
      for (int i = 0; i < NROW; i++) begin
         exp = BW'(2000);
         if (vecDone === 1'b1) dones++;
         checks++;
         if (outValid !== 1'b1 || outRowIdx !== 4'(i) || outData !== exp) begin
            errors++;
            $display("FAIL b2b_b%0d got v=%b row=%0d d=%0d want 1 %0d %0d", i, outValid, outRowIdx, $signed(outData), i, $signed(exp));
         end
         @(negedge clock);
      end
      checks++;
      if (dones != 1) begin
         errors++; $display("FAIL b2b_done_count got %0d want 1", dones);
      end
      checks++;
      if (vecDone !== 1'b1 || outValid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got done=%b v=%b ovr=%b want 1 0 0", vecDone, outValid, overrun);
      end
      @(negedge clock);
   endtask

   task automatic test_overrun_abort();
      logic [BW-1:0] exp;
      for (int i = 0; i < NROW; i++) begin
         dv[i] = BW'(3 * i);
         bv[i] = BW'(1);
      end
      outReady  = 1'b1;
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      for (int i = 0; i <= 9; i++) begin
         exp = BW'(3 * i + 1);
         checks++;
         if (outValid !== 1'b1 || outRowIdx !== 4'(i) || outData !== exp) begin
            errors++;
            $display("FAIL ovr_row%0d got v=%b row=%0d d=%0d want 1 %0d %0d", i, outValid, outRowIdx, $signed(outData), i, $signed(exp));
         end
         checks++;
         if (overrun !== (i > 5)) begin
            errors++; $display("FAIL ovr_flag%0d got %b want %b", i, overrun, i > 5);
         end
         if (i == 5) begin
            for (int j = 0; j < NROW; j++) begin
               dv[j] = BW'(9999);
               bv[j] = '0;
            end
            dataReady = 1'b1;
         end
         if (i == 9) begin
            reset = 1'b0;
            #1;
            checks++;
            if (outValid !== 1'b0 || busy !== 1'b0) begin
               errors++; $display("FAIL abort_valid got v=%b b=%b want 0 0", outValid, busy);
            end
            checks++;
            if (overrun !== 1'b0 || outData !== '0 || outRowIdx !== 4'd0) begin
               errors++;
               $display("FAIL abort_state got ovr=%b d=%0d row=%0d want 0 0 0", overrun, $signed(outData), outRowIdx);
            end
         end else begin
            @(negedge clock);
            dataReady = 1'b0;
         end
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (outValid !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL after_abort got v=%b ovr=%b want 0 0", outValid, overrun);
      end
   endtask

   initial begin
      for (int i = 0; i < NROW; i++) begin
         dv[i] = '0;
         bv[i] = '0;
      end
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_overrun_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
